regfile_read_mux_n: RTL and testbench

Parametrised successor to the 4-entry, 46-bit register-select mux.
- Holds DEPTH registers of WIDTH bits with one synchronous write port and NUM_RD independent registered read ports.
- Each read port selects a register by address and supports optional write-to-read bypass and a hardwired-zero entry 0.
- Sits between the datapath writeback stage and operand fetch. It replaces the discrete registers plus combinational select used today.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_rd_port.sv | 80 ++++++++
 rtl/regfile_read_mux_n.sv | 71 +++++++
 tb/tb_regfile_read_mux_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and read-source encoding for the
// parametrised register file with registered read ports.
package regfile_pkg;

    localparam int DEF_WIDTH  = 46;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BYPASS,
        SRC_MEM,
        SRC_ERR
    } rd_src_e;

    // A single-entry file still needs one address bit so that address 1 can be flagged.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: decodes the address, picks the source and
// registers data, valid and error flags with one cycle of latency.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    input  logic             i_wr_legal,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [WIDTH-1:0] i_mem [DEPTH],
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_rd_err
);

    rd_src_e          w_src;
    logic [WIDTH-1:0] w_mem_word;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_err;

    always_comb begin
        w_mem_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_addr == AW'(i)) begin
                w_mem_word = i_mem[i];
            end
        end
    end

    // Range check first, then the hardwired zero, then the same-cycle write.
    always_comb begin
        w_src = SRC_MEM;
        if (32'(i_rd_addr) >= 32'(DEPTH)) begin
            w_src = SRC_ERR;
        end else if (ZERO_REG && i_rd_addr == '0) begin
            w_src = SRC_ZERO;
        end else if (BYPASS && i_wr_legal && i_wr_addr == i_rd_addr) begin
            w_src = SRC_BYPASS;
        end
    end

    always_comb begin
        w_sel = '0;
        case (w_src)
            SRC_BYPASS: w_sel = i_wr_data;
            SRC_MEM:    w_sel = w_mem_word;
            default:    w_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= i_rd_en;
            r_err   <= i_rd_en && (w_src == SRC_ERR);
            if (i_rd_en) begin
                r_data <= w_sel;
            end
        end
    end

    assign o_rd_data  = r_data;
    assign o_rd_valid = r_valid;
    assign o_rd_err   = r_err;

endmodule

// File: rtl/regfile_read_mux_n.sv
// Register file with one synchronous write port and NUM_RD independent
// registered read ports; sits between writeback and operand fetch.
module regfile_read_mux_n
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_valid,
    output logic [NUM_RD-1:0]       rd_err
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_legal;

    // Out-of-range writes and writes to a hardwired-zero entry are dropped here,
    // so the read ports can trust this flag for bypass as well.
    assign w_wr_legal = wr_en && (32'(wr_addr) < 32'(DEPTH)) && !(ZERO_REG && wr_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_legal && wr_addr == AW'(i)) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .WIDTH    (WIDTH),
                .DEPTH    (DEPTH),
                .AW       (AW),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .clk        (clk),
                .rst        (rst),
                .i_rd_en    (rd_en[gi]),
                .i_rd_addr  (rd_addr[gi*AW +: AW]),
                .i_wr_legal (w_wr_legal),
                .i_wr_addr  (wr_addr),
                .i_wr_data  (wr_data),
                .i_mem      (r_mem),
                .o_rd_data  (rd_data[gi*WIDTH +: WIDTH]),
                .o_rd_valid (rd_valid[gi]),
                .o_rd_err   (rd_err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_read_mux_n.sv
// Two instances share all inputs: A uses defaults, B is DEPTH=3, no bypass,
// hardwired-zero entry 0. Directed steps, then random traffic against a model.
module tb_regfile_read_mux_n;
    import regfile_pkg::*;

    localparam int W = 46;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           wr_en;
    logic [1:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic [1:0]     rd_en;
    logic [3:0]     rd_addr;
    logic [2*W-1:0] a_data, b_data;
    logic [1:0]     a_valid, a_err, b_valid, b_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [W-1:0] ma [4];
    logic [W-1:0] mb [4];
    logic [W-1:0] xa_data [2];
    logic [W-1:0] xb_data [2];
    logic [1:0]   xa_valid, xa_err, xb_valid, xb_err;
    logic [W-1:0] vals [4] = '{46'h111, 46'h222, 46'h333, 46'h2AAAAAAAAAAA};

    regfile_read_mux_n dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid), .rd_err(a_err)
    );

    regfile_read_mux_n #(.WIDTH(W), .DEPTH(3), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid), .rd_err(b_err)
    );

    function automatic bit wr_legal(input int depth, input bit zr);
        return wr_en && (int'(wr_addr) < depth) && !(zr && wr_addr == 2'd0);
    endfunction

    function automatic logic [W-1:0] ref_rd(input logic [W-1:0] m [4], input int depth,
                                            input bit zr, input bit byp, input int addr,
                                            output bit err);
        rd_src_e src;
        if (addr >= depth)                                         src = SRC_ERR;
        else if (zr && addr == 0)                                  src = SRC_ZERO;
        else if (byp && wr_legal(depth, zr) && int'(wr_addr) == addr) src = SRC_BYPASS;
        else                                                       src = SRC_MEM;
        err = (src == SRC_ERR);
        case (src)
            SRC_BYPASS: return wr_data;
            SRC_MEM:    return m[addr];
            default:    return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit we, input int wa, input logic [W-1:0] wd,
                         input logic [1:0] re, input int a0, input int a1);
        rst     = r;
        wr_en   = we;
        wr_addr = 2'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = {2'(a1), 2'(a0)};
    endtask

    // Predict outputs from the pre-edge inputs, clock once, update model, compare.
    task automatic step();
        logic [W-1:0] na [2];
        logic [W-1:0] nb [2];
        bit ea [2];
        bit eb [2];
        bit la, lb;
        for (int p = 0; p < 2; p++) begin
            na[p] = ref_rd(ma, 4, 1'b0, 1'b1, int'(rd_addr[p*2 +: 2]), ea[p]);
            nb[p] = ref_rd(mb, 3, 1'b1, 1'b0, int'(rd_addr[p*2 +: 2]), eb[p]);
        end
        la = wr_legal(4, 1'b0);
        lb = wr_legal(3, 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ma[i] = '0;
                mb[i] = '0;
            end
            xa_valid = '0; xa_err = '0; xb_valid = '0; xb_err = '0;
            for (int p = 0; p < 2; p++) begin
                xa_data[p] = '0;
                xb_data[p] = '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                xa_valid[p] = rd_en[p];
                xb_valid[p] = rd_en[p];
                xa_err[p]   = rd_en[p] && ea[p];
                xb_err[p]   = rd_en[p] && eb[p];
                if (rd_en[p]) begin
                    xa_data[p] = na[p];
                    xb_data[p] = nb[p];
                end
            end
            if (la) ma[wr_addr] = wr_data;
            if (lb) mb[wr_addr] = wr_data;
        end
        chk("a_valid", W'(a_valid), W'(xa_valid));
        chk("a_err",   W'(a_err),   W'(xa_err));
        chk("a_data0", a_data[0 +: W], xa_data[0]);
        chk("a_data1", a_data[W +: W], xa_data[1]);
        chk("b_valid", W'(b_valid), W'(xb_valid));
        chk("b_err",   W'(b_err),   W'(xb_err));
        chk("b_data0", b_data[0 +: W], xb_data[0]);
        chk("b_data1", b_data[W +: W], xb_data[1]);
        $display("[TB] cycle %0d rst=%0b we=%0b wa=%0d re=%b ra=%h a_v=%b a_e=%b b_v=%b b_e=%b",
                 cyc, rst, wr_en, wr_addr, rd_en, rd_addr, a_valid, a_err, b_valid, b_err);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        // Reset held two cycles with a write and reads pending: all dropped.
        drive(1, 1, 0, 46'h3FFF_FFFF_FFFF, 2'b11, 1, 2); step();
        drive(1, 1, 3, 46'h3FFF_FFFF_FFFF, 2'b11, 3, 0); step();
        drive(0, 0, 0, '0, 2'b11, 0, 1); step();
        drive(0, 0, 0, '0, 2'b11, 2, 3); step();

        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i, vals[i], 2'b00, 0, 0); step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, '0, 2'b11, i, 3 - i); step();
        end

        // Same-cycle write and read of address 2.
        drive(0, 1, 2, 46'h5, 2'b00, 0, 0); step();
        drive(0, 1, 2, 46'h9, 2'b11, 2, 2); step();
        drive(0, 0, 0, '0,    2'b11, 2, 2); step();

        drive(0, 1, 0, 46'hABC,  2'b00, 0, 0); step();
        drive(0, 0, 0, '0,       2'b11, 0, 0); step();
        drive(0, 1, 1, 46'h1234, 2'b00, 0, 0); step();
        drive(0, 0, 0, '0,       2'b11, 1, 1); step();

        // Address 3 is out of range for B only.
        drive(0, 1, 3, 46'h3FFF_FFFF_FFFF, 2'b11, 3, 0); step();
        drive(0, 0, 0, '0, 2'b11, 1, 2); step();
        drive(0, 0, 0, '0, 2'b01, 3, 3); step();
        drive(0, 0, 0, '0, 2'b00, 3, 3); step();

        drive(0, 0, 0, '0, 2'b11, 1, 2); step();
        drive(1, 0, 0, '0, 2'b11, 1, 2); step();
        drive(0, 0, 0, '0, 2'b11, 1, 2); step();
        drive(0, 0, 0, '0, 2'b00, 0, 0); step();

        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 31) == 0, 1'($urandom), int'($urandom_range(0, 3)),
                  W'({$urandom(), $urandom()}), 2'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
